mem_arb: RTL and testbench
==========================

# mem_arb

Two-requester, single-outstanding memory arbiter sharing one backing memory port between the instruction-fetch path and the load/store path of the RV32 core. It sits between the core's fetch/LSU request interfaces and a variable-latency memory with a req/gnt/rvalid handshake. It accepts one request at a time, holds it stable until the memory grants it, and routes the response back to the owner. The core can then run against a single-port SRAM or bus instead of split, zero-latency iram/dram.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; the mask width is DATA_W/8
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted (one-cycle pulse)
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- ls_req  in  1  load/store request; held with its payload stable until ls_gnt
- ls_wen  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_wmask  in  DATA_W/8  store byte mask
- ls_gnt  out  1  load/store request accepted (pulse)
- ls_rvalid  out  1  load data valid, or store acknowledge (pulse)
- ls_rdata  out  DATA_W  load data
- mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/1/ADDR_W/DATA_W/DATA_W/8  registered request to memory
- mem_gnt  in  1  memory accepted mem_req this cycle
- mem_rvalid  in  1  memory response valid; also required for stores
- mem_rdata  in  DATA_W  memory response data
- err  out  1  sticky protocol error flag

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - When any request is pending, pick a winner and pulse the winner's gnt combinationally in the same cycle.
  - Latch the winner's payload into the mem_* registers and latch owner (0 = IF, 1 = LS).
  - Move to REQ.
- REQ:
  - Hold mem_req=1 with mem_wen/addr/wdata/wmask constant.
  - When mem_gnt=1, deassert mem_req on the next edge and move to WAIT.
- WAIT:
  - When mem_rvalid=1, pulse the owner's rvalid combinationally in the same cycle (if_rvalid when owner=0, ls_rvalid when owner=1) and move to IDLE.
- Data routing:
  - if_rdata and ls_rdata are both driven from mem_rdata.
  - Each is valid only while its rvalid is high.
- Arbitration (default): fixed priority; LS wins over IF on a simultaneous request.
- Fetch has no RAM-level byte masking.
  - When IF owns the bus: mem_wen=0 and mem_wmask=0.
- Error conditions (each sets err=1):
  - mem_rvalid=1 in IDLE or REQ; the response is dropped and no rvalid pulse is produced.
  - mem_gnt=1 in IDLE or WAIT; it is ignored.
- Clearing err: err clears only on reset.
- Requests arriving while the FSM is in REQ or WAIT get no gnt. The requester keeps req high.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0, owner=0, err=0.
  - if_gnt, ls_gnt, if_rvalid and ls_rvalid are all 0 during reset.
- Reset is asynchronous and takes effect mid-operation. An in-flight transaction is abandoned and no rvalid is produced for it.
- Minimum transaction (zero-wait memory):
  - Cycle N: gnt.
  - Cycle N+1: mem_req, with mem_gnt=1.
  - Cycle N+2: mem_rvalid and the owner's rvalid.
  - Cycle N+3: next gnt possible.
  - Request-to-data latency is 2 cycles; throughput is 1 access per 3 cycles.
- mem_gnt arriving k cycles late stretches REQ by k cycles. mem_rvalid arriving k cycles late stretches WAIT by k cycles.
- mem_gnt and mem_rvalid both high in REQ:
  - mem_gnt is taken and the FSM moves to WAIT.
  - mem_rvalid is treated as an error (err=1); the WAIT state then still waits for a fresh mem_rvalid.
- No combinational path exists from mem_gnt to any mem_* output. The paths from req to gnt and from mem_rvalid to the owner's rvalid are combinational.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last_owner register resets to 0 (IF), so the first contested grant goes to LS.
  - On a simultaneous request, grant the requester that is not last_owner.
  - last_owner updates on every grant.
- MEM_ARB_RR_EN undefined: fixed LS-over-IF priority; no last_owner register.
- Uncontested requests behave identically in both builds.

## Test plan
- Fetch only:
  - Stimulus: if_addr=0x8000_0000, memory with zero wait and rdata=0x0000_0013.
  - Required: if_gnt at cycle 0, mem_req at cycle 1, if_rvalid at cycle 2 with if_rdata=0x13; ls_gnt and ls_rvalid stay 0.
- Store with back-pressure:
  - Stimulus: ls_wen=1, ls_addr=0x8000_0104, ls_wdata=0xDEAD_BEEF, ls_wmask=0xC; mem_gnt held low for 3 cycles.
  - Required: mem_req high for 4 cycles with the payload stable, then ls_rvalid on the ack; err stays 0.
- Simultaneous if_req and ls_req:
  - Default build: LS granted first; IF granted in the cycle after ls_rvalid.
  - MEM_ARB_RR_EN build: LS granted first, then IF; a second contested pair goes LS again (alternating).
- Reset mid-transaction:
  - Stimulus: assert rst=0 while in WAIT.
  - Required: mem_req=0, state=IDLE and no rvalid pulse, asynchronously. After release, a new fetch completes normally.
- Spurious response:
  - Stimulus: mem_rvalid=1 while in IDLE.
  - Required: err=1 from the next edge and it stays high; no rvalid pulse; a subsequent transaction still completes.
- Late response:
  - Stimulus: mem_rvalid delayed 5 cycles after mem_gnt.
  - Required: FSM stays in WAIT with mem_req=0, and no gnt for a pending if_req until the cycle after rvalid.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: two-requester, single-outstanding memory arbiter.
//
// Shares one req/gnt/rvalid memory port between the instruction-fetch (if_*)
// and load/store (ls_*) paths. One transaction is in flight at a time. The
// winner's payload is captured into registered mem_* outputs and held until
// mem_gnt. The response is routed back to the owner.
//
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata        fetch path
//   ls_req/ls_wen/ls_addr/ls_wdata/ls_wmask
//                  -> ls_gnt, ls_rvalid, ls_rdata        load/store path
//   mem_req/mem_wen/mem_addr/mem_wdata/mem_wmask         registered memory request
//   mem_gnt, mem_rvalid, mem_rdata                       memory handshake/response
//   err                                                  sticky protocol error
//
// Configuration:
//   MEM_ARB_RR_EN  defined   : round-robin arbitration using a last_owner register
//                  undefined : fixed priority, LS over IF

module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state;
    logic   owner;      // 0 = IF, 1 = LS
    logic   pick_ls;    // arbitration result, meaningful only in IDLE

`ifdef MEM_ARB_RR_EN
    logic   last_owner;

    // On contention, the requester that was not granted last wins.
    always_comb begin
        pick_ls = ls_req && (!if_req || !last_owner);
    end
`else
    always_comb begin
        pick_ls = ls_req;
    end
`endif

    // Grants and rvalids are combinational. Grants are gated by rst, so no
    // gnt is seen while reset is held even with a request present.
    always_comb begin
        if_gnt    = rst && (state == IDLE) && if_req && !pick_ls;
        ls_gnt    = rst && (state == IDLE) && pick_ls;
        if_rvalid = (state == WAIT) && mem_rvalid && !owner;
        ls_rvalid = (state == WAIT) && mem_rvalid && owner;
        if_rdata  = mem_rdata;
        ls_rdata  = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            err        <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_rvalid || mem_gnt)
                        err <= 1'b1;
                    if (if_req || ls_req) begin
                        owner   <= pick_ls;
                        mem_req <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_owner <= pick_ls;
`endif
                        if (pick_ls) begin
                            mem_wen   <= ls_wen;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_wmask <= ls_wmask;
                        end else begin
                            // Fetches never write and carry no byte mask.
                            mem_wen   <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    // A response before the grant has been taken is dropped.
                    if (mem_rvalid)
                        err <= 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_gnt)
                        err <= 1'b1;
                    if (mem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [31:0] IA = 32'h8000_0000;
    localparam logic [31:0] LA = 32'h8000_0104;
    localparam logic [31:0] LD = 32'hDEAD_BEEF;
    localparam logic [3:0]  LM = 4'hC;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              ls_req, ls_wen;
    logic [31:0]       ls_addr, ls_wdata;
    logic [3:0]        ls_wmask;
    logic              ls_gnt, ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              mem_req, mem_wen;
    logic [31:0]       mem_addr, mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_gnt, mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              err;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req, ls_req, mem_gnt, mem_rvalid;
        logic [31:0] mem_rdata;
        logic        e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_rvalid, e_mem_req;
        logic        chk_pay;
        logic [31:0] e_addr;
        logic        e_wen;
        logic [3:0]  e_wmask;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ir, lr, mg, mv, input logic [31:0] rd,
        input logic eig, elg, eiv, elv, emr,
        input logic cp, input logic [31:0] ea, input logic ew,
        input logic [3:0] em, input logic [31:0] ewd);
        vec_t v;
        v.if_req = ir; v.ls_req = lr; v.mem_gnt = mg; v.mem_rvalid = mv;
        v.mem_rdata = rd;
        v.e_if_gnt = eig; v.e_ls_gnt = elg; v.e_if_rvalid = eiv;
        v.e_ls_rvalid = elv; v.e_mem_req = emr;
        v.chk_pay = cp; v.e_addr = ea; v.e_wen = ew; v.e_wmask = em;
        v.e_wdata = ewd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 4 units after it, well clear of either edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b1; if_addr = IA;
        ls_req = 1'b0; ls_wen = 1'b1; ls_addr = LA; ls_wdata = LD; ls_wmask = LM;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // ---- Reset state (if_req held high: no grant during reset) ----
        repeat (2) @(posedge clk);
        #4;
        chk("rst if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // ---- Vector table ----
        // store with back-pressure: mem_req held 4 cycles
        vecs.push_back(mk(0,1,0,0,0,       0,1,0,0,0, 1,32'd0,0,4'd0,32'd0));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,1,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,0,1,0,       0,0,0,1,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0, 1,LA,1,LM,LD));
        // fetch only, zero-wait memory
        vecs.push_back(mk(1,0,0,0,0,       1,0,0,0,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,1,0,0,       0,0,0,0,1, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,0,0,1,32'h13,  0,0,1,0,0, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,0,0,0,32'h13,  0,0,0,0,0, 1,IA,0,4'd0,32'd0));
        // contested: LS first, IF in the cycle after ls_rvalid
        vecs.push_back(mk(1,1,0,0,0,       0,1,0,0,0, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(1,0,1,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(1,0,0,1,32'h55,  0,0,0,1,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(1,0,0,0,0,       1,0,0,0,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,1,0,0,       0,0,0,0,1, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,0,0,1,32'h77,  0,0,1,0,0, 1,IA,0,4'd0,32'd0));
        // second contested pair after an IF grant: LS in both builds
        vecs.push_back(mk(1,1,0,0,0,       0,1,0,0,0, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(1,0,1,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(1,1,0,1,32'h99,  0,0,0,1,0, 1,LA,1,LM,LD));
        // contested pair after an LS grant: builds differ
`ifdef MEM_ARB_RR_EN
        vecs.push_back(mk(1,1,0,0,0,       1,0,0,0,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,1,1,0,0,       0,0,0,0,1, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,1,0,1,32'hAA,  0,0,1,0,0, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,1,0,0,0,       0,1,0,0,0, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,0,1,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,0,1,32'hBB,  0,0,0,1,0, 1,LA,1,LM,LD));
`else
        vecs.push_back(mk(1,1,0,0,0,       0,1,0,0,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(1,0,1,0,0,       0,0,0,0,1, 1,LA,1,LM,LD));
        vecs.push_back(mk(1,0,0,1,32'hAA,  0,0,0,1,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(1,0,0,0,0,       1,0,0,0,0, 1,LA,1,LM,LD));
        vecs.push_back(mk(0,0,1,0,0,       0,0,0,0,1, 1,IA,0,4'd0,32'd0));
        vecs.push_back(mk(0,0,0,1,32'hBB,  0,0,1,0,0, 1,IA,0,4'd0,32'd0));
`endif
        vecs.push_back(mk(0,0,0,0,0,       0,0,0,0,0, 0,32'd0,0,4'd0,32'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            if_req = vecs[i].if_req; ls_req = vecs[i].ls_req;
            mem_gnt = vecs[i].mem_gnt; mem_rvalid = vecs[i].mem_rvalid;
            mem_rdata = vecs[i].mem_rdata;
            settle();
            chk($sformatf("v%0d if_gnt", i), {31'd0, if_gnt}, {31'd0, vecs[i].e_if_gnt});
            chk($sformatf("v%0d ls_gnt", i), {31'd0, ls_gnt}, {31'd0, vecs[i].e_ls_gnt});
            chk($sformatf("v%0d if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].e_if_rvalid});
            chk($sformatf("v%0d ls_rvalid", i), {31'd0, ls_rvalid}, {31'd0, vecs[i].e_ls_rvalid});
            chk($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_mem_req});
            chk($sformatf("v%0d err", i), {31'd0, err}, 32'd0);
            if (vecs[i].e_if_rvalid)
                chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].mem_rdata);
            if (vecs[i].e_ls_rvalid)
                chk($sformatf("v%0d ls_rdata", i), ls_rdata, vecs[i].mem_rdata);
            if (vecs[i].chk_pay) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d mem_wen", i), {31'd0, mem_wen}, {31'd0, vecs[i].e_wen});
                chk($sformatf("v%0d mem_wmask", i), {28'd0, mem_wmask}, {28'd0, vecs[i].e_wmask});
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            cyc();
        end
        if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // ---- Late response: WAIT stretched 5 cycles, pending fetch blocked ----
        cyc(); ls_req = 1'b1; settle();
        chk("late ls_gnt", {31'd0, ls_gnt}, 32'd1);
        cyc(); ls_req = 1'b0; mem_gnt = 1'b1; settle();
        chk("late mem_req", {31'd0, mem_req}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(); mem_gnt = 1'b0; if_req = 1'b1; settle();
            chk($sformatf("late%0d if_gnt", k), {31'd0, if_gnt}, 32'd0);
            chk($sformatf("late%0d mem_req", k), {31'd0, mem_req}, 32'd0);
            chk($sformatf("late%0d ls_rvalid", k), {31'd0, ls_rvalid}, 32'd0);
        end
        cyc(); mem_rvalid = 1'b1; settle();
        chk("late ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        chk("late if_gnt@rvalid", {31'd0, if_gnt}, 32'd0);
        cyc(); mem_rvalid = 1'b0; settle();
        chk("late if_gnt after", {31'd0, if_gnt}, 32'd1);
        cyc(); if_req = 1'b0; mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; settle();
        chk("late fetch if_rvalid", {31'd0, if_rvalid}, 32'd1);
        cyc(); mem_rvalid = 1'b0; settle();
        chk("late err", {31'd0, err}, 32'd0);

        // ---- mem_gnt and mem_rvalid together in REQ ----
        cyc(); if_req = 1'b1; settle();
        chk("both if_gnt", {31'd0, if_gnt}, 32'd1);
        cyc(); if_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; settle();
        chk("both if_rvalid in REQ", {31'd0, if_rvalid}, 32'd0);
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b0; settle();
        chk("both err", {31'd0, err}, 32'd1);
        chk("both mem_req", {31'd0, mem_req}, 32'd0);
        cyc(); mem_rvalid = 1'b1; settle();
        chk("both fresh if_rvalid", {31'd0, if_rvalid}, 32'd1);
        cyc(); mem_rvalid = 1'b0; settle();
        chk("both err sticky", {31'd0, err}, 32'd1);

        // ---- Reset in WAIT: asynchronous, no rvalid, clears err ----
        cyc(); if_req = 1'b1;
        cyc(); if_req = 1'b0; mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst err", {31'd0, err}, 32'd0);
        chk("arst mem_addr", mem_addr, 32'd0);
        chk("arst mem_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; if_req = 1'b1;
        #1;
        chk("arst if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("arst if_gnt", {31'd0, if_gnt}, 32'd0);
        cyc(); settle();
        chk("arst held mem_req", {31'd0, mem_req}, 32'd0);
        cyc(); mem_rvalid = 1'b0; if_req = 1'b0; rst = 1'b1;
        cyc(); if_req = 1'b1; settle();
        chk("post-rst if_gnt", {31'd0, if_gnt}, 32'd1);
        cyc(); if_req = 1'b0; mem_gnt = 1'b1; settle();
        chk("post-rst mem_addr", mem_addr, IA);
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; settle();
        chk("post-rst if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("post-rst if_rdata", if_rdata, 32'h13);

        // ---- Spurious response in IDLE ----
        cyc(); settle();
        chk("spur if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("spur ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        chk("spur err same cycle", {31'd0, err}, 32'd0);
        cyc(); mem_rvalid = 1'b0; settle();
        chk("spur err", {31'd0, err}, 32'd1);
        cyc(); if_req = 1'b1; settle();
        chk("spur next if_gnt", {31'd0, if_gnt}, 32'd1);
        cyc(); if_req = 1'b0; mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
        chk("spur next if_rvalid", {31'd0, if_rvalid}, 32'd1);
        cyc(); mem_rvalid = 1'b0; settle();
        chk("spur err sticky", {31'd0, err}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
